// File: rtl/debug_trace_ctrl.sv
// debug_trace_ctrl: trigger-based trace capture for the core debug bundle.
// Arms on request, triggers on a pc match (or the first sample), captures
// DEPTH non-stalled {pc, instruction} pairs, then streams them out bytewise.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for arm; buffer contents are stale
// ARMED    | waiting for the first non-stalled trigger hit
// CAPTURE  | storing one entry per non-stalled cycle until DEPTH entries
// DUMP     | streaming entries 0..DEPTH-1, 8 bytes each, MSB first
module debug_trace_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dbg_pc,
  input  logic [31:0]      dbg_instruction,
  input  logic             dbg_i_cache_stall,
  input  logic             dbg_d_cache_stall,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_pc_en,
  input  logic [31:0]      trig_pc,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] entry_count,
  output logic             done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DUMP    = 2'd3
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [2:0]       r_byte_idx;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic [63:0]      r_buf [DEPTH];

  logic             w_sample;
  logic             w_hit;
  logic [63:0]      w_entry;
  logic             w_wr_en;
  logic             w_wr_last;
  logic             w_accept;
  logic             w_last_byte;
  logic             w_last_entry;
  logic [63:0]      w_first_entry;
  logic [63:0]      w_cur_entry;
  logic [63:0]      w_next_entry;

  // Byte idx of an entry, idx 0 being the most significant byte.
  function automatic logic [7:0] f_byte(input logic [63:0] ent, input logic [2:0] idx);
    logic [5:0] sh;
    sh = {~idx, 3'b000};
    return ent[sh +: 8];
  endfunction

  assign w_sample     = !dbg_i_cache_stall && !dbg_d_cache_stall;
  assign w_hit        = w_sample && (!trig_pc_en || (dbg_pc == trig_pc));
  assign w_entry      = {dbg_pc, dbg_instruction};
  assign w_wr_last    = (r_wr_ptr == AW'(DEPTH - 1));
  assign w_accept     = r_out_valid && out_ready;
  assign w_last_byte  = (r_byte_idx == 3'd7);
  assign w_last_entry = (r_rd_ptr == AW'(DEPTH - 1));
  assign w_cur_entry  = r_buf[r_rd_ptr];
  assign w_next_entry = r_buf[r_rd_ptr + AW'(1)];

  // Entry 0 is still on the input bus only when the trigger cycle also fills the buffer.
  assign w_first_entry = (r_state == S_ARMED) ? w_entry : r_buf[0];

  assign w_wr_en = !rst && !abort &&
                   (((r_state == S_ARMED) && w_hit) ||
                    ((r_state == S_CAPTURE) && w_sample));

  // Done is combinational so it coincides with the final handshake.
  assign done = (r_state == S_DUMP) && w_accept && w_last_byte && w_last_entry &&
                !abort && !rst;

  assign state       = r_state;
  assign entry_count = r_count;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;

  // Trace buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_ptr] <= w_entry;
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_byte_idx  <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_state  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_hit) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= CNT_W'(1);
            if (w_wr_last) begin
              r_state     <= S_DUMP;
              r_rd_ptr    <= '0;
              r_byte_idx  <= '0;
              r_out_valid <= 1'b1;
              r_out_data  <= f_byte(w_first_entry, 3'd0);
            end else begin
              r_state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (w_sample) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= r_count + CNT_W'(1);
            if (w_wr_last) begin
              r_state     <= S_DUMP;
              r_rd_ptr    <= '0;
              r_byte_idx  <= '0;
              r_out_valid <= 1'b1;
              r_out_data  <= f_byte(w_first_entry, 3'd0);
            end
          end
        end
        S_DUMP: begin
          if (w_accept) begin
            if (!w_last_byte) begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_out_data <= f_byte(w_cur_entry, r_byte_idx + 3'd1);
            end else if (w_last_entry) begin
              r_state     <= S_IDLE;
              r_byte_idx  <= '0;
              r_rd_ptr    <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
            end else begin
              r_rd_ptr   <= r_rd_ptr + AW'(1);
              r_byte_idx <= '0;
              r_out_data <= f_byte(w_next_entry, 3'd0);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_trace_ctrl.sv
// Testbench for debug_trace_ctrl: a vector table for the arm/trigger
// corner cases, then whole traces checked against a model that picks the
// captured samples straight from the stimulus and flattens them to bytes.
module tb_debug_trace_ctrl;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NS    = 64;

  logic             clk;
  logic             rst;
  logic [31:0]      dbg_pc;
  logic [31:0]      dbg_instruction;
  logic             dbg_i_cache_stall;
  logic             dbg_d_cache_stall;
  logic             arm;
  logic             abort;
  logic             trig_pc_en;
  logic [31:0]      trig_pc;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] entry_count;
  logic             done;

  int checks   = 0;
  int failures = 0;

  debug_trace_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .dbg_pc            (dbg_pc),
    .dbg_instruction   (dbg_instruction),
    .dbg_i_cache_stall (dbg_i_cache_stall),
    .dbg_d_cache_stall (dbg_d_cache_stall),
    .arm               (arm),
    .abort             (abort),
    .trig_pc_en        (trig_pc_en),
    .trig_pc           (trig_pc),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .state             (state),
    .entry_count       (entry_count),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        a_arm;
    logic        a_abort;
    logic        a_si;
    logic        a_sd;
    logic        a_ten;
    logic [31:0] a_pc;
    logic [31:0] a_tpc;
    logic [1:0]  e_state;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic ab, input logic si, input logic sd,
                              input logic te, input logic [31:0] pc, input logic [31:0] tp,
                              input logic [1:0] st, input int cnt);
    vec_t v;
    v.a_arm   = a;
    v.a_abort = ab;
    v.a_si    = si;
    v.a_sd    = sd;
    v.a_ten   = te;
    v.a_pc    = pc;
    v.a_tpc   = tp;
    v.e_state = st;
    v.e_cnt   = cnt[CNT_W-1:0];
    return v;
  endfunction

  // One complete trace: generate stimulus, derive the expected byte stream,
  // then drive and compare cycle by cycle. intr_kind 1 = abort, 2 = rst.
  task automatic run_trace(input int mode, input int intr_kind, input int intr_cyc, input string tag);
    logic [31:0] spc [NS];
    logic [31:0] sins [NS];
    logic        ssi [NS];
    logic        ssd [NS];
    int          cum [NS];
    logic [7:0]  exp_b [$];
    logic        ten;
    logic [31:0] tpc;
    logic [63:0] ent;
    bit          trig;
    int          n_ent;
    int          nb;
    int          ndone;
    int          dump_cyc;
    int          ec;
    int          es;
    logic        pv;
    logic        pr;
    logic [7:0]  pd;
    bit          fin;
    bit          completed;

    ten = 1'b0;
    tpc = 32'h0;
    for (int c = 0; c < NS; c++) begin
      sins[c] = $urandom;
      ssi[c]  = 1'b0;
      ssd[c]  = 1'b0;
      case (mode)
        0: spc[c] = 32'(4 * c);
        1: begin spc[c] = 32'(4 * c); ten = 1'b1; tpc = 32'h40; end
        2: begin spc[c] = 32'h1000 + 32'(4 * c); ssd[c] = (c % 2) == 1; end
        default: begin
          spc[c] = $urandom;
          ssi[c] = ($urandom_range(0, 7) == 0);
          ssd[c] = ($urandom_range(0, 3) == 0);
        end
      endcase
    end
    if (mode == 3) begin
      ten    = 1'b1;
      tpc    = spc[7];
      ssi[7] = 1'b0;
      ssd[7] = 1'b0;
    end

    trig  = 1'b0;
    n_ent = 0;
    for (int c = 0; c < NS; c++) begin
      if (n_ent < DEPTH && !ssi[c] && !ssd[c] && (trig || !ten || spc[c] == tpc)) begin
        trig = 1'b1;
        ent  = {spc[c], sins[c]};
        for (int b = 0; b < 8; b++) exp_b.push_back(8'(ent >> (56 - 8 * b)));
        n_ent++;
      end
      cum[c] = n_ent;
    end

    @(negedge clk);
    arm       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_armed"}, 64'(state), 64'd1);

    nb = 0; ndone = 0; dump_cyc = 0;
    pv = 1'b0; pr = 1'b0; pd = 8'h0;
    fin = 1'b0; completed = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      arm = 1'b0;
      if (fin) begin
        check({tag, "_idle_after_done"}, 64'(state), 64'd0);
        check({tag, "_valid_after_done"}, 64'(out_valid), 64'd0);
        completed = 1'b1;
        break;
      end
      if (c < NS) begin
        dbg_pc            = spc[c];
        dbg_instruction   = sins[c];
        dbg_i_cache_stall = ssi[c];
        dbg_d_cache_stall = ssd[c];
      end else begin
        dbg_pc            = $urandom;
        dbg_instruction   = $urandom;
        dbg_i_cache_stall = 1'b0;
        dbg_d_cache_stall = 1'b0;
      end
      trig_pc_en = ten;
      trig_pc    = tpc;
      out_ready  = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (intr_kind != 0 && c == intr_cyc) begin
        if (intr_kind == 1) abort = 1'b1;
        else rst = 1'b1;
      end
      #1;
      ec = (c == 0) ? 0 : cum[(c - 1 < NS) ? c - 1 : NS - 1];
      es = (ec == 0) ? 1 : (ec < DEPTH) ? 2 : 3;
      check({tag, "_state"}, 64'(state), 64'(es));
      check({tag, "_entry_count"}, 64'(entry_count), 64'(ec));
      check({tag, "_valid_in_dump"}, 64'(out_valid), 64'(es == 3));
      if (pv && !pr) begin
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(out_data), 64'(pd));
      end
      if (state == 2'd3) dump_cyc++;
      if (intr_kind != 0 && c == intr_cyc) begin
        check({tag, "_no_done_on_intr"}, 64'(done), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        rst   = 1'b0;
        check({tag, "_intr_state"}, 64'(state), 64'd0);
        check({tag, "_intr_count"}, 64'(entry_count), 64'd0);
        check({tag, "_intr_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_intr_done"}, 64'(done), 64'd0);
        if (intr_kind == 2) check({tag, "_rst_data"}, 64'(out_data), 64'd0);
        check({tag, "_no_done_before_intr"}, 64'(ndone), 64'd0);
        return;
      end
      if (out_valid && out_ready) begin
        if (nb < exp_b.size()) check({tag, "_byte"}, 64'(out_data), 64'(exp_b[nb]));
        if (mode == 0 && nb < 4) check({tag, "_pc0_byte"}, 64'(out_data), 64'd0);
        if (mode == 1 && nb == 3) check({tag, "_trig_pc_lsb"}, 64'(out_data), 64'h40);
        nb++;
      end
      if (done) begin
        ndone++;
        check({tag, "_done_at_last_byte"}, 64'(nb), 64'(8 * DEPTH));
        fin = 1'b1;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
    if (!completed) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d bytes, expected %0d and done", tag, nb, 8 * DEPTH);
    end
    check({tag, "_byte_total"}, 64'(nb), 64'(8 * DEPTH));
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
    if (mode != 3) check({tag, "_dump_cycles"}, 64'(dump_cyc), 64'(8 * DEPTH));
  endtask

  vec_t vecs [16];

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h00, 32'h40, 2'd0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 32'h00, 32'h40, 2'd0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 32'h00, 32'h40, 2'd1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 32'h10, 32'h40, 2'd1, 0);
    vecs[4]  = mk(0, 0, 1, 0, 1, 32'h40, 32'h40, 2'd1, 0);
    vecs[5]  = mk(0, 0, 0, 1, 1, 32'h40, 32'h40, 2'd1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 1, 32'h44, 32'h40, 2'd1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 32'h40, 32'h40, 2'd2, 1);
    vecs[8]  = mk(0, 0, 0, 1, 1, 32'h48, 32'h40, 2'd2, 1);
    vecs[9]  = mk(0, 0, 0, 0, 1, 32'h4c, 32'h40, 2'd2, 2);
    vecs[10] = mk(1, 0, 0, 0, 1, 32'h50, 32'h40, 2'd2, 3);
    vecs[11] = mk(0, 1, 0, 0, 1, 32'h54, 32'h40, 2'd0, 0);
    vecs[12] = mk(1, 0, 0, 0, 1, 32'h58, 32'h40, 2'd1, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 32'h5c, 32'h40, 2'd1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 32'h60, 32'h40, 2'd2, 1);
    vecs[15] = mk(1, 1, 0, 0, 0, 32'h64, 32'h40, 2'd0, 0);

    rst = 1'b1; arm = 1'b0; abort = 1'b0; out_ready = 1'b0;
    dbg_pc = 32'h0; dbg_instruction = 32'h0;
    dbg_i_cache_stall = 1'b0; dbg_d_cache_stall = 1'b0;
    trig_pc_en = 1'b0; trig_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(entry_count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      arm               = vecs[i].a_arm;
      abort             = vecs[i].a_abort;
      dbg_i_cache_stall = vecs[i].a_si;
      dbg_d_cache_stall = vecs[i].a_sd;
      trig_pc_en        = vecs[i].a_ten;
      dbg_pc            = vecs[i].a_pc;
      trig_pc           = vecs[i].a_tpc;
      dbg_instruction   = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      check($sformatf("vec%0d_count", i), 64'(entry_count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    dbg_i_cache_stall = 1'b0; dbg_d_cache_stall = 1'b0;

    run_trace(0, 0, 0, "immediate");
    run_trace(1, 0, 0, "pc_trig");
    run_trace(2, 0, 0, "stall_filter");
    run_trace(3, 0, 0, "backpressure_a");
    run_trace(3, 0, 0, "backpressure_b");
    run_trace(0, 1, 5, "abort_capture");
    run_trace(0, 1, 60, "abort_dump");
    run_trace(0, 2, 80, "rst_dump");
    run_trace(0, 0, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
